// File: rtl/fwnoc_port_arb.sv
// fwnoc_port_arb: wormhole output-port arbiter for the fwnoc router.
// Shares one ready/valid output link between N_PORTS requesters. In IDLE it picks a
// header round-robin from rr_ptr. A header with a nonzero length locks the link to
// its sender until that many payload flits have transferred. Data passes through
// combinationally; the block holds no flit storage.
//
// Ports:
//   clock      - sole clock, rising edge
//   reset      - asynchronous, active-low reset
//   i_dat      - requester flits, port k at [k*DATA_WIDTH +: DATA_WIDTH]
//   i_valid    - requester flit valid
//   i_ready    - requester flit accept
//   o_dat      - output link flit
//   o_valid    - output link valid
//   o_ready    - output link accept
//   grant      - one-hot link owner, zero when there is no owner
//   busy       - high while a packet holds the link
//   stall_err  - sticky stall-watchdog error
//
// Optional build macro FWNOC_ARB_STALL_WDOG_EN: when it is defined, stall_err is set
// after STALL_LIMIT consecutive BUSY cycles without a transfer. When it is undefined,
// stall_err is tied low.
module fwnoc_port_arb #(
    parameter int unsigned N_PORTS     = 5,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned LEN_LSB     = 0,
    parameter int unsigned LEN_WIDTH   = 8,
    parameter int unsigned STALL_LIMIT = 1024
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [N_PORTS*DATA_WIDTH-1:0]   i_dat,
    input  logic [N_PORTS-1:0]              i_valid,
    output logic [N_PORTS-1:0]              i_ready,
    output logic [DATA_WIDTH-1:0]           o_dat,
    output logic                            o_valid,
    input  logic                            o_ready,
    output logic [N_PORTS-1:0]              grant,
    output logic                            busy,
    output logic                            stall_err
);

    localparam int unsigned PTR_W = $clog2(N_PORTS);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                 state, state_n;
    logic [PTR_W-1:0]       rr_ptr, rr_ptr_n;
    logic [PTR_W-1:0]       own, own_n;
    logic [LEN_WIDTH-1:0]   cnt, cnt_n;
    logic [PTR_W-1:0]       win;
    logic                   any_valid;
    logic [LEN_WIDTH-1:0]   hdr_len;
    logic                   busy_xfer;
    logic [DATA_WIDTH-1:0]  flit [N_PORTS];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(N_PORTS - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Unpack the flat requester bus into one flit per port.
    always_comb begin
        for (int unsigned k = 0; k < N_PORTS; k++) begin
            flit[k] = i_dat[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Round-robin winner: the first valid port at or after rr_ptr.
    always_comb begin
        int unsigned      idx;
        logic [PTR_W-1:0] cand;
        win       = '0;
        any_valid = 1'b0;
        idx       = 0;
        cand      = '0;
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            idx  = (32'(rr_ptr) + i) % N_PORTS;
            cand = PTR_W'(idx);
            if (!any_valid && i_valid[cand]) begin
                any_valid = 1'b1;
                win       = cand;
            end
        end
    end

    assign hdr_len   = flit[win][LEN_LSB +: LEN_WIDTH];
    assign busy_xfer = i_valid[own] && o_ready;
    assign busy      = (state == BUSY);

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            rr_ptr <= '0;
            own    <= '0;
            cnt    <= '0;
        end else begin
            state  <= state_n;
            rr_ptr <= rr_ptr_n;
            own    <= own_n;
            cnt    <= cnt_n;
        end
    end

    // Next state and link steering.
    always_comb begin
        state_n  = state;
        rr_ptr_n = rr_ptr;
        own_n    = own;
        cnt_n    = cnt;
        o_dat    = '0;
        o_valid  = 1'b0;
        i_ready  = '0;
        grant    = '0;
        case (state)
            IDLE: begin
                if (any_valid) begin
                    o_dat        = flit[win];
                    o_valid      = 1'b1;
                    i_ready[win] = o_ready;
                    grant[win]   = 1'b1;
                    if (o_ready) begin
                        if (hdr_len == '0) begin
                            rr_ptr_n = ptr_inc(win);
                        end else begin
                            state_n = BUSY;
                            own_n   = win;
                            cnt_n   = hdr_len;
                        end
                    end
                end
            end
            BUSY: begin
                o_dat        = flit[own];
                o_valid      = i_valid[own];
                i_ready[own] = o_ready;
                grant[own]   = 1'b1;
                if (busy_xfer) begin
                    cnt_n = cnt - LEN_WIDTH'(1);
                    if (cnt == LEN_WIDTH'(1)) begin
                        state_n  = IDLE;
                        rr_ptr_n = ptr_inc(own);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        // Link outputs stay quiet while reset is held, whatever the requesters drive.
        if (!reset) begin
            o_dat   = '0;
            o_valid = 1'b0;
            i_ready = '0;
            grant   = '0;
        end
    end

`ifdef FWNOC_ARB_STALL_WDOG_EN
    localparam int unsigned STALL_W = $clog2(STALL_LIMIT + 1);

    logic [STALL_W-1:0] stall_cnt, stall_cnt_n;
    logic               stall_err_n;

    // Count consecutive stalled BUSY cycles, saturating at the limit.
    always_comb begin
        stall_cnt_n = '0;
        stall_err_n = stall_err;
        if (state == BUSY && !busy_xfer) begin
            stall_cnt_n = (stall_cnt == STALL_W'(STALL_LIMIT)) ? stall_cnt
                                                               : stall_cnt + STALL_W'(1);
        end
        if (stall_cnt_n == STALL_W'(STALL_LIMIT)) begin
            stall_err_n = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            stall_err <= 1'b0;
        end else begin
            stall_cnt <= stall_cnt_n;
            stall_err <= stall_err_n;
        end
    end
`else
    logic unused_stall_limit;
    assign unused_stall_limit = ^32'(STALL_LIMIT);
    assign stall_err          = 1'b0;
`endif

endmodule

// File: tb/tb_fwnoc_port_arb.sv
// Directed bench for fwnoc_port_arb: reset, single packet, round-robin, lock under
// contention, zero/max length and the stall watchdog.
module tb_fwnoc_port_arb;

    localparam int unsigned NP = 5;
    localparam int unsigned DW = 32;
`ifdef FWNOC_ARB_STALL_WDOG_EN
    localparam bit WDOG = 1'b1;
`else
    localparam bit WDOG = 1'b0;
`endif

    logic               clock = 1'b0;
    logic               reset = 1'b0;
    logic [NP*DW-1:0]   i_dat = '0;
    logic [NP-1:0]      i_valid = '0;
    logic [NP-1:0]      i_ready;
    logic [DW-1:0]      o_dat;
    logic               o_valid;
    logic               o_ready = 1'b0;
    logic [NP-1:0]      grant;
    logic               busy;
    logic               stall_err;

    int n_checks = 0;
    int n_fail   = 0;

    fwnoc_port_arb #(
        .N_PORTS(NP), .DATA_WIDTH(DW), .LEN_LSB(0), .LEN_WIDTH(8), .STALL_LIMIT(16)
    ) dut (
        .clock(clock), .reset(reset), .i_dat(i_dat), .i_valid(i_valid),
        .i_ready(i_ready), .o_dat(o_dat), .o_valid(o_valid), .o_ready(o_ready),
        .grant(grant), .busy(busy), .stall_err(stall_err)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_flit(input int k, input logic [DW-1:0] v);
        i_dat[k*DW +: DW] = v;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        i_valid = '0;
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        o_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            for (int k = 0; k < NP; k++) set_flit(k, $urandom);
            i_valid = NP'($urandom) | NP'(1);
            #1;
            n_checks++;
            if (o_valid !== 1'b0 || i_ready !== '0 || grant !== '0 || busy !== 1'b0 || o_dat !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs c=%0d: o_valid=%b i_ready=%b grant=%b busy=%b o_dat=%h, want all 0",
                         c, o_valid, i_ready, grant, busy, o_dat);
            end
            tick();
        end
        // First header after release goes to port 0; len=0 so the link stays IDLE.
        for (int k = 0; k < NP; k++) set_flit(k, 32'h5000_0000 | (k << 16));
        i_valid = '1;
        reset = 1'b1;
        #1;
        n_checks++;
        if (grant !== 5'b00001 || o_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_first_grant: grant=%b o_valid=%b, want 00001 1", grant, o_valid);
        end
        tick();
        i_valid = '0;
    endtask

    task automatic test_single_packet();
        logic [DW-1:0] exp_d;
        i_valid = 5'b00100;
        o_ready = 1'b1;
        set_flit(2, 32'hC0DE_0003);
        for (int j = 0; j < 4; j++) begin
            exp_d = (j == 0) ? 32'hC0DE_0003 : 32'hA0 + j;
            if (j > 0) set_flit(2, exp_d);
            #1;
            n_checks++;
            if (o_dat !== exp_d || o_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL single_data j=%0d: o_dat=%h o_valid=%b, want %h 1", j, o_dat, o_valid, exp_d);
            end
            n_checks++;
            if (grant !== 5'b00100 || i_ready !== 5'b00100 || busy !== (j > 0)) begin
                n_fail++;
                $display("FAIL single_ctrl j=%0d: grant=%b i_ready=%b busy=%b, want 00100 00100 %b",
                         j, grant, i_ready, busy, (j > 0));
            end
            tick();
        end
        i_valid = '0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || grant !== '0 || o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_idle: busy=%b grant=%b o_valid=%b, want 0 0 0", busy, grant, o_valid);
        end
    endtask

    task automatic test_round_robin();
        int exp_order [7] = '{0, 1, 2, 3, 4, 0, 1};
        logic [NP-1:0] g;
        pulse_reset();
        o_ready = 1'b1;
        for (int k = 0; k < NP; k++) set_flit(k, 32'h0000_0001 | (k << 16));
        i_valid = '1;
        for (int p = 0; p < 7; p++) begin
            g = NP'(1) << exp_order[p];
            #1;
            n_checks++;
            if (grant !== g || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL rr_header p=%0d: grant=%b busy=%b, want %b 0", p, grant, busy, g);
            end
            tick();
            set_flit(exp_order[p], 32'hB000_0000 | exp_order[p]);
            #1;
            n_checks++;
            if (grant !== g || busy !== 1'b1 || o_dat !== (32'hB000_0000 | exp_order[p])) begin
                n_fail++;
                $display("FAIL rr_payload p=%0d: grant=%b busy=%b o_dat=%h, want %b 1 %h",
                         p, grant, busy, o_dat, g, 32'hB000_0000 | exp_order[p]);
            end
            tick();
            set_flit(exp_order[p], 32'h0000_0001 | (exp_order[p] << 16));
        end
        i_valid = '0;
    endtask

    task automatic test_lock();
        int sent = 0;
        pulse_reset();
        o_ready = 1'b1;
        set_flit(0, 32'h0000_0000);
        set_flit(1, 32'h0001_0004);
        i_valid = 5'b00010;
        #1;
        n_checks++;
        if (grant !== 5'b00010) begin
            n_fail++;
            $display("FAIL lock_header: grant=%b, want 00010", grant);
        end
        tick();
        i_valid = 5'b00011;
        for (int c = 0; c < 7; c++) begin
            o_ready = (c % 2 == 0);
            set_flit(1, 32'hD0 + sent);
            #1;
            n_checks++;
            if (i_ready !== {3'b000, o_ready, 1'b0} || grant !== 5'b00010 || busy !== 1'b1
                || o_dat !== 32'hD0 + sent) begin
                n_fail++;
                $display("FAIL lock_payload c=%0d: i_ready=%b grant=%b busy=%b o_dat=%h, want %b 00010 1 %h",
                         c, i_ready, grant, busy, o_dat, {3'b000, o_ready, 1'b0}, 32'hD0 + sent);
            end
            tick();
            if (o_ready) sent++;
        end
        i_valid = 5'b00001;
        o_ready = 1'b1;
        #1;
        n_checks++;
        if (busy !== 1'b0 || grant !== 5'b00001 || i_ready !== 5'b00001) begin
            n_fail++;
            $display("FAIL lock_release: busy=%b grant=%b i_ready=%b, want 0 00001 00001", busy, grant, i_ready);
        end
        tick();
        i_valid = '0;
    endtask

    task automatic test_len_edges();
        pulse_reset();
        o_ready = 1'b1;
        set_flit(3, 32'h0300_0000);
        i_valid = 5'b01000;
        #1;
        n_checks++;
        if (grant !== 5'b01000) begin
            n_fail++;
            $display("FAIL zero_len_grant: grant=%b, want 01000", grant);
        end
        tick();
        set_flit(4, 32'h0400_0000);
        i_valid = 5'b11000;
        #1;
        n_checks++;
        if (busy !== 1'b0 || grant !== 5'b10000) begin
            n_fail++;
            $display("FAIL zero_len_next: busy=%b grant=%b, want 0 10000", busy, grant);
        end
        tick();
        set_flit(0, 32'h0000_00FF);
        set_flit(2, 32'h0200_0000);
        i_valid = 5'b00101;
        #1;
        n_checks++;
        if (grant !== 5'b00001) begin
            n_fail++;
            $display("FAIL max_len_header: grant=%b, want 00001", grant);
        end
        tick();
        for (int i = 0; i < 255; i++) begin
            set_flit(0, 32'hE000_0000 + i);
            #1;
            n_checks++;
            if (busy !== 1'b1 || grant !== 5'b00001 || o_dat !== 32'hE000_0000 + i) begin
                n_fail++;
                $display("FAIL max_len_payload i=%0d: busy=%b grant=%b o_dat=%h, want 1 00001 %h",
                         i, busy, grant, o_dat, 32'hE000_0000 + i);
            end
            tick();
        end
        i_valid = 5'b00100;
        #1;
        n_checks++;
        if (busy !== 1'b0 || grant !== 5'b00100) begin
            n_fail++;
            $display("FAIL max_len_end: busy=%b grant=%b, want 0 00100", busy, grant);
        end
        tick();
        i_valid = '0;
    endtask

    task automatic test_watchdog();
        logic exp_err;
        pulse_reset();
        o_ready = 1'b1;
        set_flit(0, 32'h0000_0002);
        i_valid = 5'b00001;
        #1;
        n_checks++;
        if (grant !== 5'b00001 || stall_err !== 1'b0) begin
            n_fail++;
            $display("FAIL wdog_start: grant=%b stall_err=%b, want 00001 0", grant, stall_err);
        end
        tick();
        i_valid = '0;
        for (int c = 1; c <= 16; c++) begin
            tick();
            exp_err = WDOG && (c >= 16);
            n_checks++;
            if (stall_err !== exp_err || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL wdog_stall c=%0d: stall_err=%b busy=%b, want %b 1", c, stall_err, busy, exp_err);
            end
        end
        i_valid = 5'b00001;
        for (int i = 0; i < 2; i++) begin
            set_flit(0, 32'hF0 + i);
            #1;
            n_checks++;
            if (o_dat !== 32'hF0 + i || o_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL wdog_resume i=%0d: o_dat=%h o_valid=%b, want %h 1", i, o_dat, o_valid, 32'hF0 + i);
            end
            tick();
        end
        i_valid = '0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || stall_err !== WDOG) begin
            n_fail++;
            $display("FAIL wdog_sticky: busy=%b stall_err=%b, want 0 %b", busy, stall_err, WDOG);
        end
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_round_robin();
        test_lock();
        test_len_edges();
        test_watchdog();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
